// File: rtl/hashfunc.sv
// hashfunc: dual-hash generator for the two-choice (cuckoo-style) bucket table.
// Each 32-bit key produces two bucket indices through a free-running 2-stage pipeline.
//
// Ports:
//   clk   - system clock, rising edge
//   rst   - asynchronous, active-high reset; clears every pipeline register
//   key   - 32-bit key, sampled on every rising edge
//   hash1 - primary bucket index. Registered; TABLE_BITS significant bits, zero-extended.
//   hash2 - alternate bucket index. Registered; TABLE_BITS significant bits, zero-extended.
//
// Optional build macro:
//   HASH_DISTINCT_EN - when defined, a hash2 index equal to the hash1 index
//                      is replaced by (hash1 + 1) mod 2^TABLE_BITS.
//
// Latency: a key sampled at edge N appears on hash1/hash2 after edge N+1.
module hashfunc #(
    parameter int unsigned TABLE_BITS = 8,
    parameter logic [31:0] K1         = 32'h9E3779B9,
    parameter logic [31:0] K2         = 32'h85EBCA6B,
    parameter logic [31:0] SEED       = 32'h00000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] key,
    output logic [31:0] hash1,
    output logic [31:0] hash2
);

    // Low bit of the index slice taken from the 32-bit product.
    localparam int unsigned SH = 32 - TABLE_BITS;

    // Stage 1 registers
    logic [31:0] k_r;
    logic [31:0] m_r;
`ifdef HASH_DISTINCT_EN
    // Marks that stage 1 holds a sampled key rather than flushed zeros.
    logic        v_r;
`endif

    // Stage 2 combinational products and index slices
    logic [31:0]           p1_c;
    logic [31:0]           p2_c;
    logic [TABLE_BITS-1:0] idx1_c;
    logic [TABLE_BITS-1:0] idx2_c;

    // Truncated multiplies followed by the top-bit index slice.
    always_comb begin
        p1_c   = k_r * K1;
        p2_c   = m_r * K2;
        idx1_c = p1_c[31:SH];
        idx2_c = p2_c[31:SH];
`ifdef HASH_DISTINCT_EN
        // Collision bump. Gated by v_r so that flushed slots read as 0 after reset.
        if (v_r && (p2_c[31:SH] == p1_c[31:SH])) begin
            idx2_c = p1_c[31:SH] + TABLE_BITS'(1);
        end
`endif
    end

    // Pipeline registers for both stages
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            k_r   <= 32'd0;
            m_r   <= 32'd0;
`ifdef HASH_DISTINCT_EN
            v_r   <= 1'b0;
`endif
            hash1 <= 32'd0;
            hash2 <= 32'd0;
        end else begin
            k_r   <= key;
            m_r   <= key ^ (key >> 16) ^ SEED;
`ifdef HASH_DISTINCT_EN
            v_r   <= 1'b1;
`endif
            hash1 <= 32'(idx1_c);
            hash2 <= 32'(idx2_c);
        end
    end

endmodule

// File: tb/tb_hashfunc.sv
// tb_hashfunc: self-checking bench for hashfunc. It runs one TABLE_BITS=8 instance
// and one TABLE_BITS=4 instance, both driven by the same key. A reference model
// checks every cycle, and hand-computed literals pin down the model.
`timescale 1ns/1ps
module tb_hashfunc;

    localparam logic [31:0] K1   = 32'h9E3779B9;
    localparam logic [31:0] K2   = 32'h85EBCA6B;
    localparam logic [31:0] SEED = 32'h00000000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] key = 32'd0;
    logic [31:0] h1_a, h2_a, h1_b, h2_b;

    int errors = 0;
    int checks = 0;

    hashfunc #(.TABLE_BITS(8), .K1(K1), .K2(K2), .SEED(SEED)) dut_a (
        .clk(clk), .rst(rst), .key(key), .hash1(h1_a), .hash2(h2_a));

    hashfunc #(.TABLE_BITS(4), .K1(K1), .K2(K2), .SEED(SEED)) dut_b (
        .clk(clk), .rst(rst), .key(key), .hash1(h1_b), .hash2(h2_b));

    always #5 clk = ~clk;

    // Reference: bucket index = top tb bits of (x * k) mod 2^32.
    function automatic logic [31:0] top_idx(input logic [31:0] x, input logic [31:0] k,
                                            input int tb);
        logic [63:0] prod;
        logic [31:0] low;
        prod = 64'(x) * 64'(k);
        low  = prod[31:0];
        return low >> (32 - tb);
    endfunction

    function automatic logic [31:0] ref_h1(input logic [31:0] k, input int tb);
        return top_idx(k, K1, tb);
    endfunction

    function automatic logic [31:0] ref_h2(input logic [31:0] k, input int tb);
        logic [31:0] h;
        h = top_idx(k ^ (k >> 16) ^ SEED, K2, tb);
`ifdef HASH_DISTINCT_EN
        if (h == ref_h1(k, tb)) h = (ref_h1(k, tb) + 32'd1) % (32'd1 << tb);
`endif
        return h;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%08h), expected %0d (0x%08h) at %0t",
                     name, act, act, exp, exp, $time);
        end
    endtask

    // Model history: the keys sampled on the last two edges. Reset empties it.
    logic [31:0] hist_k [2];
    logic        hist_v [2];

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            hist_v[0] = 1'b0;
            hist_v[1] = 1'b0;
            hist_k[0] = 32'd0;
            hist_k[1] = 32'd0;
        end else begin
            hist_k[1] = hist_k[0];
            hist_v[1] = hist_v[0];
            hist_k[0] = key;
            hist_v[0] = 1'b1;
        end
    end

    // Continuous compare: the outputs reflect the key sampled two edges ago, or 0 if that slot is empty.
    always @(negedge clk) begin
        chk("model_h1_tb8", h1_a, hist_v[1] ? ref_h1(hist_k[1], 8) : 32'd0);
        chk("model_h2_tb8", h2_a, hist_v[1] ? ref_h2(hist_k[1], 8) : 32'd0);
        chk("model_h1_tb4", h1_b, hist_v[1] ? ref_h1(hist_k[1], 4) : 32'd0);
        chk("model_h2_tb4", h2_b, hist_v[1] ? ref_h2(hist_k[1], 4) : 32'd0);
    end

    // Hold key k for two edges so its result is on the outputs at the following negedge.
    task automatic settle(input logic [31:0] k);
        @(negedge clk);
        key = k;
        repeat (2) @(negedge clk);
    endtask

    logic [31:0] seq [4];

    initial begin
        seq[0] = 32'd279; seq[1] = 32'd19; seq[2] = 32'd8; seq[3] = 32'd28;

        // Outputs are cleared while reset is held.
        #2;
        chk("reset_h1", h1_a, 32'd0);
        chk("reset_h2", h2_a, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // key = 1 gives the top bits of K1 and K2.
        settle(32'd1);
        chk("key1_h1", h1_a, 32'd158);
        chk("key1_h2", h2_a, 32'd133);
        chk("key1_tb4_h1", h1_b, 32'd9);
        chk("key1_tb4_h2", h2_b, 32'd8);
        chk("key1_tb4_upper0", h1_b | h2_b, h1_b[3:0] | h2_b[3:0]);

        settle(32'd279);
        chk("key279_h1", h1_a, 32'd110);
        chk("key279_h2", h2_a, 32'd243);

        // Back-to-back keys, one per edge. Each result appears two edges after its key.
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            key = seq[i];
            @(negedge clk);
        end
        @(negedge clk);
        chk("b2b_last_h1", h1_a, ref_h1(32'd28, 8));

        // key 0 maps to hash2 = 0, or to 1 when the collision bump is enabled.
        settle(32'd0);
        chk("key0_h1", h1_a, 32'd0);
`ifdef HASH_DISTINCT_EN
        chk("key0_h2", h2_a, 32'd1);
`else
        chk("key0_h2", h2_a, 32'd0);
`endif

        // Asynchronous reset asserted mid-cycle while outputs are nonzero.
        settle(32'd279);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_h1", h1_a, 32'd0);
        chk("async_rst_h2", h2_a, 32'd0);
        chk("async_rst_tb4_h1", h1_b, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_1edge_h1", h1_a, 32'd0);
        chk("post_rst_1edge_h2", h2_a, 32'd0);
        @(negedge clk);
        chk("post_rst_2edge_h1", h1_a, 32'd110);
        chk("post_rst_2edge_h2", h2_a, 32'd243);

        // A short burst of pseudo-random keys, checked by the continuous compare.
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            key = $urandom;
        end
        repeat (3) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
